hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning number of architectural registers (power of two, >=2).
REQ-002 SHALL have parameter DEPTH, default 4, meaning stall cycles between a producer and a back-to-back dependent consumer with no forwarding (1..15).
REQ-003 SHALL have parameter FWD, default 0, meaning 0 = no forwarding, 1 = full forwarding except load-use.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 1, meaning bubbles inserted after an accepted control-transfer instruction (0..7).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode slot holds an instruction
- id_rs  in  RW  first source register, RW = clog2(NUM_REGS)
- id_rs_used  in  1  id_rs is read
- id_rt  in  RW  second source register
- id_rt_used  in  1  id_rt is read
- id_rd  in  RW  destination register
- id_wr_en  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a memory load
- id_is_ctrl  in  1  instruction is a jump/branch/jr
- stall  out  1  hold PC and decode register this cycle
- nop  out  1  inject bubble into the next stage this cycle
- busy_vec  out  NUM_REGS  bit i = register i has a pending write

Function
REQ-006 SHALL keep one down-counter per register, width clog2(DEPTH+1); busy_vec[i] = (counter i != 0).
REQ-007 SHALL compute hazard = id_valid & ((id_rs_used & busy[id_rs]) | (id_rt_used & busy[id_rt])), combinationally from the current counters.
REQ-008 SHALL keep a flush counter, width 3; flush_active = (flush counter != 0).
REQ-009 SHALL drive stall = hazard & ~flush_active.
REQ-010 SHALL drive nop = stall | flush_active.
REQ-011 SHALL define accept = id_valid & ~stall & ~flush_active; an instruction presented during flush_active is squashed and leaves no scoreboard or flush effect.
REQ-012 On accept with id_wr_en, SHALL load counter[id_rd] at the clock edge with:
- DEPTH when FWD=0;
- 1 when FWD=1 and id_is_load;
- 0 (no effect) when FWD=1 and not a load.
REQ-013 Every non-zero counter not being loaded SHALL decrement by 1 each edge; zero counters SHALL hold.
REQ-014 When a load and a decrement target the same register in the same edge, SHALL apply the load (the newest producer wins).
REQ-015 On accept with id_is_ctrl, SHALL load the flush counter with FLUSH_CYCLES; otherwise a non-zero flush counter SHALL decrement by 1 each edge.
REQ-016 An accepted instruction that is both a control transfer and a writer (e.g. jal) SHALL update both counters.
REQ-017 Resulting latency: a dependent instruction presented the cycle after its producer is accepted SHALL be held exactly DEPTH cycles (FWD=0), 1 cycle (FWD=1 load), or 0 cycles (FWD=1 ALU).
REQ-018 id_valid=0 SHALL produce stall=0, with nop = flush_active, and SHALL not stop counters decrementing.

Reset
REQ-019 Asserting rst SHALL asynchronously clear all register counters and the flush counter, without waiting for a clock edge.
REQ-020 While rst is high, stall=0, nop=0, busy_vec=0.
REQ-021 Asserting rst mid-stall or mid-flush SHALL discard all pending state; the first cycle after release SHALL behave as an empty scoreboard.

Structure
REQ-022 A shared package hazard_pkg SHALL hold the default parameter constants and the counter-width calculation helper.
REQ-023 Per-register counter logic (load, decrement, busy) SHALL be one sub-module, hazard_sb_entry, instantiated NUM_REGS times.

Verification
REQ-024 With FWD=0, DEPTH=4: accept write r3 at cycle 0, then present a reader of r3 from cycle 1 -> stall=nop=1 in cycles 1-4, accept at cycle 5, busy_vec[3] clears at cycle 5.
REQ-025 With FWD=1: accept load r2, then present a reader of r2 -> exactly 1 stall cycle; accept ALU write r2, then present a reader of r2 -> 0 stall cycles.
REQ-026 With FLUSH_CYCLES=2: accept a branch at cycle 0 -> nop=1 and stall=0 in cycles 1-2; an instruction writing r5 presented in cycle 1 leaves busy_vec[5]=0.
REQ-027 Write r1 (counter 4), then write r1 again 2 cycles later -> counter reloads to 4, and a reader stalls until 4 cycles after the second write.
REQ-028 rst pulsed asynchronously between edges during a 4-cycle stall -> stall and busy_vec drop to 0 immediately, and the reader is accepted at the first edge after release.
REQ-029 With NUM_REGS=16, DEPTH=6: a reader presented back-to-back after a write to r15 -> stall for 6 cycles, while readers of unrelated registers r0-r14 see no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared defaults and sizing helper for the decode-stage hazard scoreboard.
package hazard_pkg;
    localparam int HZ_NUM_REGS     = 8;
    localparam int HZ_DEPTH        = 4;
    localparam int HZ_FWD          = 0;
    localparam int HZ_FLUSH_CYCLES = 1;
    localparam int HZ_FLUSH_W      = 3;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// One register's pending-write down-counter; busy while non-zero.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int CW = cnt_width(HZ_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_en_i,
    input  logic [CW-1:0] load_val_i,
    output logic          busy_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    // A fresh producer overrides any countdown still in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (load_en_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: stalls readers of pending registers, bubbles after control transfers.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = HZ_NUM_REGS,
    parameter int DEPTH        = HZ_DEPTH,
    parameter int FWD          = HZ_FWD,
    parameter int FLUSH_CYCLES = HZ_FLUSH_CYCLES,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [RW-1:0]       id_rs,
    input  logic                id_rs_used,
    input  logic [RW-1:0]       id_rt,
    input  logic                id_rt_used,
    input  logic [RW-1:0]       id_rd,
    input  logic                id_wr_en,
    input  logic                id_is_load,
    input  logic                id_is_ctrl,
    output logic                stall,
    output logic                nop,
    output logic [NUM_REGS-1:0] busy_vec
);
    localparam int CW = cnt_width(DEPTH);

    logic [NUM_REGS-1:0]   busy;
    logic [HZ_FLUSH_W-1:0] flush_q, flush_d;
    logic                  flush_active;
    logic                  hazard;
    logic                  accept;
    logic                  wr_accept;
    logic [CW-1:0]         load_val;

    assign flush_active = (flush_q != '0);
    assign hazard       = id_valid & ((id_rs_used & busy[id_rs]) | (id_rt_used & busy[id_rt]));
    assign stall        = hazard & ~flush_active;
    assign nop          = stall | flush_active;
    assign accept       = id_valid & ~stall & ~flush_active;
    assign busy_vec     = busy;

    // With forwarding only a load result arrives too late for the next instruction.
    always_comb begin
        load_val = '0;
        if (FWD == 0) begin
            load_val = CW'(DEPTH);
        end else if (id_is_load) begin
            load_val = CW'(1);
        end
    end

    assign wr_accept = accept & id_wr_en & (load_val != '0);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        hazard_sb_entry #(
            .CW(CW)
        ) u_entry (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_en_i  (wr_accept & (id_rd == RW'(i))),
            .load_val_i (load_val),
            .busy_o     (busy[i])
        );
    end

    always_comb begin
        flush_d = flush_q;
        if (accept & id_is_ctrl) begin
            flush_d = HZ_FLUSH_W'(FLUSH_CYCLES);
        end else if (flush_active) begin
            flush_d = flush_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= '0;
        end else begin
            flush_q <= flush_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: three scoreboard configurations share stimulus, one selected per vector.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic [1:0]  dut;
        logic        stall;
        logic        nop;
        logic [15:0] busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   sel = 0;
    logic vld = 1'b0;
    logic [3:0] rs = '0, rt = '0, rd = '0;
    logic rsu = 1'b0, rtu = 1'b0, wr = 1'b0, ld = 1'b0, ct = 1'b0;

    logic        stall0, nop0, stall1, nop1, stall2, nop2;
    logic [7:0]  busy0, busy1;
    logic [15:0] busy2;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    // dut0: no forwarding, DEPTH 4, 2 flush bubbles
    hazard_scoreboard #(.NUM_REGS(8), .DEPTH(4), .FWD(0), .FLUSH_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(vld && sel == 0),
        .id_rs(rs[2:0]), .id_rs_used(rsu), .id_rt(rt[2:0]), .id_rt_used(rtu),
        .id_rd(rd[2:0]), .id_wr_en(wr), .id_is_load(ld), .id_is_ctrl(ct),
        .stall(stall0), .nop(nop0), .busy_vec(busy0));

    // dut1: full forwarding, 1 flush bubble
    hazard_scoreboard #(.NUM_REGS(8), .DEPTH(4), .FWD(1), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(vld && sel == 1),
        .id_rs(rs[2:0]), .id_rs_used(rsu), .id_rt(rt[2:0]), .id_rt_used(rtu),
        .id_rd(rd[2:0]), .id_wr_en(wr), .id_is_load(ld), .id_is_ctrl(ct),
        .stall(stall1), .nop(nop1), .busy_vec(busy1));

    // dut2: 16 registers, DEPTH 6
    hazard_scoreboard #(.NUM_REGS(16), .DEPTH(6), .FWD(0), .FLUSH_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(vld && sel == 2),
        .id_rs(rs), .id_rs_used(rsu), .id_rt(rt), .id_rt_used(rtu),
        .id_rd(rd), .id_wr_en(wr), .id_is_load(ld), .id_is_ctrl(ct),
        .stall(stall2), .nop(nop2), .busy_vec(busy2));

    task automatic drv(input int d, input logic v, input logic [3:0] a_rs, input logic a_rsu,
                       input logic [3:0] a_rt, input logic a_rtu, input logic [3:0] a_rd,
                       input logic a_wr, input logic a_ld, input logic a_ct);
        @(posedge clk);
        #1;
        sel = d; vld = v; rs = a_rs; rsu = a_rsu; rt = a_rt; rtu = a_rtu;
        rd = a_rd; wr = a_wr; ld = a_ld; ct = a_ct;
    endtask

    task automatic push(input int d, input logic s, input logic n, input logic [15:0] b,
                        input string nm);
        exp_t e;
        e.dut = 2'(d); e.stall = s; e.nop = n; e.busy = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every queued expectation against the selected DUT mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic        a_s, a_n;
            logic [15:0] a_b;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e.dut)
                2'd0:    begin a_s = stall0; a_n = nop0; a_b = {8'h00, busy0}; end
                2'd1:    begin a_s = stall1; a_n = nop1; a_b = {8'h00, busy1}; end
                default: begin a_s = stall2; a_n = nop2; a_b = busy2; end
            endcase
            n_chk++;
            if (a_s !== e.stall || a_n !== e.nop || a_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s: got stall=%b nop=%b busy=%h, want stall=%b nop=%b busy=%h",
                         nm, a_s, a_n, a_b, e.stall, e.nop, e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state for every configuration.
        drv(0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "rst_dut0");
        push(1, 0, 0, 16'h0, "rst_dut1");
        push(2, 0, 0, 16'h0, "rst_dut2");
        @(negedge clk);
        #2 rst = 1'b0;

        // Back-to-back dependency, no forwarding: 4 stall cycles.
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "dep_write_r3");
        for (int c = 1; c <= 4; c++) begin
            drv(0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            push(0, 1, 1, 16'h0008, $sformatf("dep_stall_c%0d", c));
        end
        drv(0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "dep_accept_c5");
        idle(2);

        // Branch with two bubbles; the writer of r5 in the shadow is squashed.
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        push(0, 0, 0, 16'h0, "br_accept");
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        push(0, 0, 1, 16'h0, "br_bubble1");
        drv(0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 1, 16'h0, "br_bubble2_idle");
        drv(0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "br_done_r5_clear");

        // jal: control transfer and writer of r6 at once.
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1);
        push(0, 0, 0, 16'h0, "jal_accept");
        drv(0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 1, 16'h0040, "jal_flush1");
        drv(0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 1, 16'h0040, "jal_flush2");
        drv(0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 1, 1, 16'h0040, "jal_stall_cnt2");
        drv(0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 1, 1, 16'h0040, "jal_stall_cnt1");
        drv(0, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "jal_reader_accept");
        idle(2);

        // Rewrite of r1 restarts its countdown; unused source fields are ignored.
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "rw_first_write");
        drv(0, 1'b1, 4'd1, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0002, "rw_unused_rs");
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0002, "rw_second_write");
        for (int c = 3; c <= 6; c++) begin
            drv(0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
            push(0, 1, 1, 16'h0002, $sformatf("rw_rt_stall_c%0d", c));
        end
        drv(0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "rw_accept_c7");
        idle(2);

        // Async reset during a stall, reader accepted at the first edge after release.
        drv(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0, "ar_write_r3");
        drv(0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        push(0, 1, 1, 16'h0008, "ar_stall");
        drv(0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        push(0, 0, 0, 16'h0, "ar_in_reset");
        @(negedge clk);
        #2 rst = 1'b0;
        drv(0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(0, 0, 0, 16'h0010, "ar_reader_accepted");
        idle(5);

        // Forwarding: load-use costs 1 cycle, ALU producer costs none.
        drv(1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
        push(1, 0, 0, 16'h0, "fwd_load_r2");
        drv(1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(1, 1, 1, 16'h0004, "fwd_load_use_stall");
        drv(1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(1, 0, 0, 16'h0, "fwd_load_use_accept");
        drv(1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        push(1, 0, 0, 16'h0, "fwd_alu_r2");
        drv(1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        push(1, 0, 0, 16'h0, "fwd_alu_reader");
        drv(1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        push(1, 0, 0, 16'h0, "fwd_branch");
        drv(1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(1, 0, 1, 16'h0, "fwd_bubble");
        drv(1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(1, 0, 0, 16'h0, "fwd_after_bubble");

        // 16 registers, DEPTH 6: reader of r15 stalls 6 cycles.
        drv(2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
        push(2, 0, 0, 16'h0, "w16_write_r15");
        for (int c = 1; c <= 6; c++) begin
            drv(2, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            push(2, 1, 1, 16'h8000, $sformatf("w16_stall_c%0d", c));
        end
        drv(2, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        push(2, 0, 0, 16'h0, "w16_accept_c7");

        // Unrelated readers r0..r14 never stall while r15 is pending.
        drv(2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
        push(2, 0, 0, 16'h0, "w16_rewrite_r15");
        for (int k = 0; k < 15; k++) begin
            drv(2, 1'b1, 4'(k), 1'b1, 4'(14 - k), 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
            push(2, 0, 0, (k < 6) ? 16'h8000 : 16'h0000, $sformatf("w16_unrelated_r%0d", k));
        end

        idle(3);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
